instr_encode_loader: RTL and testbench

//  Builds 32-bit RV32I instruction words from separate fields (R-type, and I-type ADDI-class) and writes them
//  one after another into instruction memory. A load session runs from start to finish.

---
 rtl/instr_encode_loader.sv | 168 ++++++++++++++++
 tb/tb_instr_encode_loader.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encode_loader.sv
// instr_encode_loader
//   Encodes RV32I R-type and I-type (ADDI-class) instruction words from separate fields and
//   writes them to consecutive instruction-memory word addresses during a load session.
//   A small show-ahead FIFO decouples the field source from the memory write port.
//
// Ports
//   clk_i, rst_ni       clock (rising edge), asynchronous active-low reset
//   start_i             pulse: begin a load session (IDLE only)
//   finish_i            pulse: stop accepting beats and drain the FIFO (LOAD only)
//   in_valid_i/in_ready_o  field-beat handshake
//   in_fmt_i            0 = R-type, 1 = I-type
//   in_rd_i, in_rs1_i, in_rs2_i, in_funct3_i, in_funct7_i, in_imm_i  instruction fields
//   mem_we_o/mem_ready_i   write handshake; mem_addr_o/mem_wdata_o hold while stalled
//   count_o             words written this session, saturating
//   imm_err_o           sticky: an I-type immediate was out of range (beat dropped)
//   busy_o              session in LOAD or DRAIN
//   done_o              one-cycle pulse when the drain completes
module instr_encode_loader #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              finish_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic              in_fmt_i,
  input  logic [4:0]        in_rd_i,
  input  logic [4:0]        in_rs1_i,
  input  logic [4:0]        in_rs2_i,
  input  logic [2:0]        in_funct3_i,
  input  logic [6:0]        in_funct7_i,
  input  logic [31:0]       in_imm_i,
  output logic              mem_we_o,
  input  logic              mem_ready_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic [ADDR_W:0]   count_o,
  output logic              imm_err_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [6:0] OpcOp    = 7'b0110011;
  localparam logic [6:0] OpcOpImm = 7'b0010011;

  typedef enum logic [1:0] {StIdle, StLoad, StDrain, StDone} state_e;

  state_e state_q, state_d;

  logic [31:0]       fifo_mem [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]     occ_q, occ_d;
  logic              full, empty;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              imm_err_q, imm_err_d;

  logic              imm_ok;
  logic [31:0]       enc_word;
  logic              accept, push, pop;
  logic              sess_start;

  assign full  = (occ_q == (PtrW + 1)'(DEPTH));
  assign empty = (occ_q == '0);

  // Immediate fits in 12 signed bits when bits 31..11 are all copies of the sign.
  assign imm_ok = (&in_imm_i[31:11]) | ~(|in_imm_i[31:11]);

  always_comb begin
    enc_word = '0;
    if (in_fmt_i) begin
      enc_word = {in_imm_i[11:0], in_rs1_i, in_funct3_i, in_rd_i, OpcOpImm};
    end else begin
      enc_word = {in_funct7_i, in_rs2_i, in_rs1_i, in_funct3_i, in_rd_i, OpcOp};
    end
  end

  assign in_ready_o  = (state_q == StLoad) && !full;
  assign accept      = in_valid_i && in_ready_o;
  // Out-of-range I-type beats are consumed but never reach the FIFO.
  assign push        = accept && (!in_fmt_i || imm_ok);
  assign mem_we_o    = !empty && ((state_q == StLoad) || (state_q == StDrain));
  assign pop         = mem_we_o && mem_ready_i;
  assign mem_wdata_o = empty ? 32'h0 : fifo_mem[rd_ptr_q];
  assign mem_addr_o  = addr_q;
  assign count_o     = count_q;
  assign imm_err_o   = imm_err_q;
  assign busy_o      = (state_q == StLoad) || (state_q == StDrain);
  assign done_o      = (state_q == StDone);
  assign sess_start  = (state_q == StIdle) && start_i;

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_i)  state_d = StLoad;
      StLoad:  if (finish_i) state_d = StDrain;
      StDrain: if (empty)    state_d = StDone;
      StDone:                state_d = StIdle;
      default:               state_d = StIdle;
    endcase
  end

  // Occupancy and session bookkeeping
  always_comb begin
    occ_d     = occ_q;
    addr_d    = addr_q;
    count_d   = count_q;
    imm_err_d = imm_err_q;
    unique case ({push, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
    if (sess_start) begin
      addr_d    = ADDR_W'(BASE_ADDR);
      count_d   = '0;
      imm_err_d = 1'b0;
    end else begin
      if (pop) begin
        addr_d = addr_q + 1'b1;
        if (count_q != '1) begin
          count_d = count_q + 1'b1;
        end
      end
      if (accept && in_fmt_i && !imm_ok) begin
        imm_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      occ_q     <= '0;
      addr_q    <= ADDR_W'(BASE_ADDR);
      count_q   <= '0;
      imm_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      occ_q     <= occ_d;
      addr_q    <= addr_d;
      count_q   <= count_d;
      imm_err_q <= imm_err_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  // Storage needs no reset: occupancy gates every read.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= enc_word;
    end
  end

endmodule

// File: tb/tb_instr_encode_loader.sv
// Testbench for instr_encode_loader: two instances (ADDR_W=10 and ADDR_W=2) share stimulus and
// are checked every cycle against a queue-based session model, plus directed spot checks.
module tb_instr_encode_loader;

  localparam int unsigned Depth = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0, finish_i = 1'b0, in_valid_i = 1'b0, in_fmt_i = 1'b0;
  logic [4:0]  in_rd_i = '0, in_rs1_i = '0, in_rs2_i = '0;
  logic [2:0]  in_funct3_i = '0;
  logic [6:0]  in_funct7_i = '0;
  logic [31:0] in_imm_i = '0;
  logic        mem_ready_i = 1'b0;

  logic        a_ready, a_we, a_err, a_busy, a_done;
  logic [9:0]  a_addr;
  logic [31:0] a_wdata;
  logic [10:0] a_count;
  logic        b_ready, b_we, b_err, b_busy, b_done;
  logic [1:0]  b_addr;
  logic [31:0] b_wdata;
  logic [2:0]  b_count;

  always #5 clk_i = ~clk_i;

  instr_encode_loader #(.DEPTH(Depth), .ADDR_W(10), .BASE_ADDR(0)) dut_a (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .finish_i(finish_i),
    .in_valid_i(in_valid_i), .in_ready_o(a_ready), .in_fmt_i(in_fmt_i), .in_rd_i(in_rd_i),
    .in_rs1_i(in_rs1_i), .in_rs2_i(in_rs2_i), .in_funct3_i(in_funct3_i),
    .in_funct7_i(in_funct7_i), .in_imm_i(in_imm_i), .mem_we_o(a_we), .mem_ready_i(mem_ready_i),
    .mem_addr_o(a_addr), .mem_wdata_o(a_wdata), .count_o(a_count), .imm_err_o(a_err),
    .busy_o(a_busy), .done_o(a_done)
  );

  instr_encode_loader #(.DEPTH(Depth), .ADDR_W(2), .BASE_ADDR(0)) dut_b (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .finish_i(finish_i),
    .in_valid_i(in_valid_i), .in_ready_o(b_ready), .in_fmt_i(in_fmt_i), .in_rd_i(in_rd_i),
    .in_rs1_i(in_rs1_i), .in_rs2_i(in_rs2_i), .in_funct3_i(in_funct3_i),
    .in_funct7_i(in_funct7_i), .in_imm_i(in_imm_i), .mem_we_o(b_we), .mem_ready_i(mem_ready_i),
    .mem_addr_o(b_addr), .mem_wdata_o(b_wdata), .count_o(b_count), .imm_err_o(b_err),
    .busy_o(b_busy), .done_o(b_done)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: 0 idle, 1 loading, 2 draining, 3 done.
  int          phase = 0;
  logic [31:0] q[$];
  int unsigned wr_cnt = 0;
  bit          m_err = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit imm_in_range(input logic [31:0] imm);
    return ($signed(imm) >= -2048) && ($signed(imm) <= 2047);
  endfunction

  function automatic logic [31:0] encode_now();
    logic [31:0] rd, rs1, rs2, f3, f7, imm;
    rd = 32'(in_rd_i); rs1 = 32'(in_rs1_i); rs2 = 32'(in_rs2_i);
    f3 = 32'(in_funct3_i); f7 = 32'(in_funct7_i); imm = in_imm_i & 32'hFFF;
    if (in_fmt_i) return (imm << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h13;
    return (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h33;
  endfunction

  task automatic model_reset();
    q.delete();
    phase  = 0;
    wr_cnt = 0;
    m_err  = 1'b0;
  endtask

  task automatic model_step();
    int ph;
    bit was_empty, acc, wr;
    if (!rst_ni) begin
      model_reset();
      return;
    end
    ph        = phase;
    was_empty = (q.size() == 0);
    acc       = (ph == 1) && (q.size() < Depth) && in_valid_i;
    wr        = !was_empty && (ph == 1 || ph == 2) && mem_ready_i;
    if (wr) begin
      void'(q.pop_front());
      wr_cnt++;
    end
    if (acc) begin
      if (in_fmt_i && !imm_in_range(in_imm_i)) m_err = 1'b1;
      else q.push_back(encode_now());
    end
    case (ph)
      0: if (start_i) begin phase = 1; wr_cnt = 0; m_err = 1'b0; end
      1: if (finish_i) phase = 2;
      2: if (was_empty) phase = 3;
      default: phase = 0;
    endcase
  endtask

  task automatic compare_all();
    logic [31:0] head;
    bit          busy;
    head = (q.size() > 0) ? q[0] : 32'h0;
    busy = (phase == 1 || phase == 2);
    check("a_in_ready", a_ready, (phase == 1) && (q.size() < Depth));
    check("a_mem_we", a_we, (q.size() > 0) && busy);
    check("a_mem_wdata", a_wdata, head);
    check("a_mem_addr", a_addr, wr_cnt % 1024);
    check("a_count", a_count, (wr_cnt > 2047) ? 2047 : wr_cnt);
    check("a_imm_err", a_err, m_err);
    check("a_busy", a_busy, busy);
    check("a_done", a_done, phase == 3);
    check("b_mem_we", b_we, (q.size() > 0) && busy);
    check("b_mem_wdata", b_wdata, head);
    check("b_mem_addr", b_addr, wr_cnt % 4);
    check("b_count", b_count, (wr_cnt > 7) ? 7 : wr_cnt);
    check("b_imm_err", b_err, m_err);
    check("b_done", b_done, phase == 3);
  endtask

  // Called at a negedge with inputs set; returns at the next negedge after checking outputs.
  task automatic step();
    model_step();
    @(posedge clk_i);
    @(negedge clk_i);
    compare_all();
    start_i    = 1'b0;
    finish_i   = 1'b0;
    in_valid_i = 1'b0;
  endtask

  task automatic beat_i(input logic [4:0] rd, input logic [4:0] rs1, input logic [2:0] f3,
                        input logic [31:0] imm);
    in_valid_i = 1'b1; in_fmt_i = 1'b1; in_rd_i = rd; in_rs1_i = rs1;
    in_funct3_i = f3; in_imm_i = imm;
    in_rs2_i = 5'($urandom); in_funct7_i = 7'($urandom);
  endtask

  task automatic beat_r(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [2:0] f3, input logic [6:0] f7);
    in_valid_i = 1'b1; in_fmt_i = 1'b0; in_rd_i = rd; in_rs1_i = rs1; in_rs2_i = rs2;
    in_funct3_i = f3; in_funct7_i = f7; in_imm_i = $urandom;
  endtask

  task automatic begin_session();
    start_i = 1'b1;
    step();
  endtask

  task automatic end_session();
    int n;
    mem_ready_i = 1'b1;
    finish_i    = 1'b1;
    step();
    n = 0;
    while (phase != 0 && n < 64) begin
      step();
      n++;
    end
    if (n >= 64) check("drain_timeout", 1, 0);
  endtask

  initial begin
    model_reset();
    @(negedge clk_i);
    compare_all();
    check("rst_mem_wdata", a_wdata, 32'h0);
    check("rst_in_ready", a_ready, 1'b0);
    rst_ni = 1'b1;
    step();

    // T1: single I-type write
    begin_session();
    mem_ready_i = 1'b1;
    beat_i(5'd1, 5'd0, 3'd0, 32'd5);
    step();
    check("t1_wdata", a_wdata, 32'h00500093);
    check("t1_addr", a_addr, 10'd0);
    step();
    check("t1_count", a_count, 11'd1);
    end_session();

    // T2: negative immediate then R-type
    begin_session();
    mem_ready_i = 1'b0;
    beat_i(5'd2, 5'd2, 3'd0, 32'hFFFF_FFFF);
    step();
    check("t2_wdata0", a_wdata, 32'hFFF10113);
    mem_ready_i = 1'b1;
    beat_r(5'd3, 5'd1, 5'd2, 3'd0, 7'd0);
    step();
    check("t2_wdata1", a_wdata, 32'h002081B3);
    check("t2_addr1", a_addr, 10'd1);
    end_session();

    // T3: FIFO fills while memory stalls
    begin_session();
    mem_ready_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      beat_r(5'(i + 1), 5'(i), 5'(i + 2), 3'(i), 7'h20);
      step();
    end
    check("t3_full_ready", a_ready, 1'b0);
    check("t3_addr_held", a_addr, 10'd0);
    end_session();
    check("t3_count", a_count, 11'd4);

    // T4: out-of-range immediate
    begin_session();
    mem_ready_i = 1'b1;
    beat_i(5'd4, 5'd4, 3'd0, 32'd2048);
    step();
    check("t4_imm_err", a_err, 1'b1);
    check("t4_no_write", a_we, 1'b0);
    end_session();
    begin_session();
    check("t4_err_clear", a_err, 1'b0);
    end_session();

    // T5: address wrap on the narrow instance
    begin_session();
    mem_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      beat_i(5'(i), 5'(i), 3'd0, 32'(i));
      step();
    end
    end_session();
    check("t5_b_count", b_count, 3'd5);
    check("t5_b_addr", b_addr, 2'd1);

    // T6: reset during drain
    begin_session();
    mem_ready_i = 1'b0;
    beat_i(5'd1, 5'd1, 3'd0, 32'd1);
    step();
    beat_i(5'd2, 5'd2, 3'd0, 32'd2);
    step();
    finish_i = 1'b1;
    step();
    rst_ni = 1'b0;
    #1;
    model_reset();
    compare_all();
    mem_ready_i = 1'b1;
    step();
    rst_ni = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check("t6_no_we", a_we, 1'b0);

    // Random traffic with stray start/finish pulses
    rst_ni = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      start_i     = ($urandom_range(0, 19) == 0);
      finish_i    = ($urandom_range(0, 39) == 0);
      mem_ready_i = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) != 0) begin
        if ($urandom_range(0, 1) == 0) begin
          beat_r(5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom));
        end else begin
          case ($urandom_range(0, 5))
            0:       beat_i(5'($urandom), 5'($urandom), 3'($urandom), $urandom);
            1:       beat_i(5'($urandom), 5'($urandom), 3'($urandom), 32'd2047);
            2:       beat_i(5'($urandom), 5'($urandom), 3'($urandom), 32'hFFFF_F800);
            default: beat_i(5'($urandom), 5'($urandom), 3'($urandom),
                            32'($signed(12'($urandom))));
          endcase
        end
      end
      step();
    end
    if (phase == 1 || phase == 2) end_session();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
